// File: rtl/fifo_wr_ctrl.sv
// ============================================================================
// Module   : fifo_wr_ctrl
// Purpose  : Writes one counting-pattern burst into a FIFO each time the FIFO
//            is seen empty, with settle delay, full back-pressure and abort.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_ctrl #(
   parameter int WAIT_CYC  = 10,
   parameter int BURST_LEN = 256,
   parameter int TIMEOUT   = 1024
) (
   input  logic        wr_clk,
   input  logic        rst_n,
   input  logic        fifo_empty,
   input  logic        fifo_full,
   output logic        fifo_wr_en,
   output logic [7:0]  fifo_wr_data,
   output logic        wr_busy,
   output logic [15:0] burst_cnt,
   output logic        timeout_err
);

   localparam logic [7:0]  SETTLE_LAST = 8'(WAIT_CYC - 1);
   localparam logic [9:0]  WORD_LAST   = 10'(BURST_LEN - 1);
   localparam logic [15:0] STALL_LAST  = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_WRITE  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t      state_q,  state_d;
   logic        meta_q,   empty_s_q;
   logic [7:0]  settle_q, settle_d;
   logic [9:0]  word_q,   word_d;
   logic [7:0]  data_q,   data_d;
   logic [15:0] stall_q,  stall_d;
   logic [15:0] burst_q,  burst_d;
   logic        terr_q,   terr_d;

   // fifo_empty comes from the read clock domain; only empty_s_q is used
   always_ff @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q    <= 1'b0;
         empty_s_q <= 1'b0;
      end else begin
         meta_q    <= fifo_empty;
         empty_s_q <= meta_q;
      end
   end

   always_ff @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         settle_q <= '0;
         word_q   <= '0;
         data_q   <= '0;
         stall_q  <= '0;
         burst_q  <= '0;
         terr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         word_q   <= word_d;
         data_q   <= data_d;
         stall_q  <= stall_d;
         burst_q  <= burst_d;
         terr_q   <= terr_d;
      end
   end

   assign fifo_wr_en = (state_q == S_WRITE) && !fifo_full;

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      word_d   = word_q;
      data_d   = data_q;
      stall_d  = stall_q;
      burst_d  = burst_q;
      terr_d   = terr_q;
      case (state_q)
         S_IDLE: begin
            if (empty_s_q) begin
               state_d  = S_SETTLE;
               settle_d = '0;
            end
         end
         S_SETTLE: begin
            if (!empty_s_q) begin
               state_d = S_IDLE;
            end else if (settle_q == SETTLE_LAST) begin
               state_d = S_WRITE;
               word_d  = '0;
               data_d  = '0;
               stall_d = '0;
            end else begin
               settle_d = settle_q + 8'd1;
            end
         end
         S_WRITE: begin
            if (fifo_wr_en) begin
               word_d  = word_q + 10'd1;
               data_d  = data_q + 8'd1;
               stall_d = '0;
               if (word_q == WORD_LAST) begin
                  state_d = S_DONE;
                  burst_d = burst_q + 16'd1;
               end
            end else begin
               stall_d = stall_q + 16'd1;
               if (stall_q == STALL_LAST) begin
                  state_d = S_DONE;
                  terr_d  = 1'b1;
               end
            end
         end
         S_DONE: begin
            // wait for the FIFO to report non-empty so a stale flag cannot re-trigger
            if (!empty_s_q) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign fifo_wr_data = data_q;
   assign wr_busy      = (state_q == S_SETTLE) || (state_q == S_WRITE);
   assign burst_cnt    = burst_q;
   assign timeout_err  = terr_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_ctrl.sv
// ============================================================================
// Module   : tb_fifo_wr_ctrl
// Purpose  : Scoreboard bench for fifo_wr_ctrl: expected write data queued by
//            stimulus, popped and compared by a negedge monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_ctrl;

   localparam int WAIT_CYC  = 10;
   localparam int BURST_LEN = 256;
   localparam int TIMEOUT   = 16;

   logic        wr_clk = 1'b0;
   logic        rst_n  = 1'b1;
   logic        fifo_empty = 1'b1;
   logic        fifo_full  = 1'b1;
   logic        fifo_wr_en;
   logic [7:0]  fifo_wr_data;
   logic        wr_busy;
   logic [15:0] burst_cnt;
   logic        timeout_err;

   int          n_chk  = 0;
   int          n_pass = 0;
   int          n_wr   = 0;
   int          base   = 0;
   int          exp_bursts = 0;
   int          exp_terr   = 0;
   logic [7:0]  exp_q[$];

   fifo_wr_ctrl #(
      .WAIT_CYC  (WAIT_CYC),
      .BURST_LEN (BURST_LEN),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .wr_clk       (wr_clk),
      .rst_n        (rst_n),
      .fifo_empty   (fifo_empty),
      .fifo_full    (fifo_full),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_data (fifo_wr_data),
      .wr_busy      (wr_busy),
      .burst_cnt    (burst_cnt),
      .timeout_err  (timeout_err)
   );

   always #5 wr_clk = ~wr_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Scoreboard monitor: every accepted write must match the head of the queue
   always @(negedge wr_clk) begin
      if (fifo_wr_en === 1'b1) begin
         n_wr++;
         check("wr_en while full", {31'd0, fifo_full}, 32'd0);
         if (exp_q.size() == 0) check("unexpected write", 32'd1, 32'd0);
         else check("wr_data", {24'd0, fifo_wr_data}, {24'd0, exp_q.pop_front()});
      end
   end

   // Reference: a burst of n words carries (i mod 256) for i = 0..n-1
   task automatic push_burst(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(8'(i % 256));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " wr_en"},   {31'd0, fifo_wr_en},   32'd0);
      check({tag, " data"},    {24'd0, fifo_wr_data}, 32'd0);
      check({tag, " busy"},    {31'd0, wr_busy},      32'd0);
      check({tag, " bursts"},  {16'd0, burst_cnt},    32'd0);
      check({tag, " terr"},    {31'd0, timeout_err},  32'd0);
   endtask

   task automatic start_burst(input int n);
      fifo_empty = 1'b0;
      repeat (4) @(posedge wr_clk);
      #1;
      base = n_wr;
      push_burst(n);
      fifo_empty = 1'b1;
   endtask

   task automatic wait_done(input string name, input int budget);
      bit ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(posedge wr_clk);
         #2;
         if (exp_q.size() == 0 && !wr_busy) begin ok = 1; break; end
      end
      check({name, " completes"}, {31'd0, ok}, 32'd1);
   endtask

   task automatic end_checks(input string name, input int n);
      check({name, " writes"}, n_wr - base,            n);
      check({name, " bursts"}, {16'd0, burst_cnt},     exp_bursts);
      check({name, " terr"},   {31'd0, timeout_err},   exp_terr);
      check({name, " busy"},   {31'd0, wr_busy},       32'd0);
   endtask

   task automatic wait_writes(input int n, input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(posedge wr_clk);
         if (n_wr - base == n) begin ok = 1; break; end
      end
   endtask

   initial begin
      bit ok;
      int lat;
      int run;
      bit seen_busy;
      logic busy_n2, busy_n3;

      // Asynchronous reset with full/empty both asserted
      #23 rst_n = 1'b0;
      #1 check_reset_outputs("por");
      @(posedge wr_clk); #1;
      rst_n = 1'b1;
      fifo_full = 1'b0;

      // Nominal burst with start latency: 2 sync + 1 IDLE->SETTLE + WAIT_CYC
      start_burst(BURST_LEN);
      lat = 0;
      busy_n2 = 1'bx; busy_n3 = 1'bx;
      for (int n = 1; n <= 40; n++) begin
         @(posedge wr_clk); #2;
         if (n == 2) busy_n2 = wr_busy;
         if (n == 3) busy_n3 = wr_busy;
         if (fifo_wr_en) begin lat = n; break; end
      end
      check("busy before settle", {31'd0, busy_n2}, 32'd0);
      check("busy in settle",     {31'd0, busy_n3}, 32'd1);
      check("first write latency", lat, 3 + WAIT_CYC);
      wait_done("nominal", 600);
      exp_bursts++;
      end_checks("nominal", BURST_LEN);
      // empty stays high: DONE must hold without re-triggering
      repeat (30) @(posedge wr_clk);
      #2;
      check("stale empty writes", n_wr - base, BURST_LEN);
      check("stale empty busy", {31'd0, wr_busy}, 32'd0);

      // Five-cycle stall after write 100
      start_burst(BURST_LEN);
      wait_writes(100, 800, ok);
      check("stall reach 100", {31'd0, ok}, 32'd1);
      #1 fifo_full = 1'b1;
      for (int j = 0; j < 5; j++) begin
         #1;
         check("stall data hold", {24'd0, fifo_wr_data}, 32'd100);
         check("stall wr_en low", {31'd0, fifo_wr_en},   32'd0);
         @(posedge wr_clk);
      end
      #1 fifo_full = 1'b0;
      #1 check("stall resume", {31'd0, fifo_wr_en}, 32'd1);
      wait_done("stall", 600);
      exp_bursts++;
      end_checks("stall", BURST_LEN);

      // Random back-pressure, runs kept below TIMEOUT
      start_burst(BURST_LEN);
      run = 0;
      ok = 0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge wr_clk); #1;
         if (run >= 6) fifo_full = 1'b0;
         else fifo_full = ($urandom_range(0, 3) == 0);
         run = fifo_full ? run + 1 : 0;
         if (exp_q.size() == 0 && !wr_busy) begin ok = 1; break; end
      end
      fifo_full = 1'b0;
      check("random completes", {31'd0, ok}, 32'd1);
      exp_bursts++;
      end_checks("random", BURST_LEN);

      // Empty glitch: 4 cycles high, abort from SETTLE with no writes
      fifo_empty = 1'b0;
      repeat (4) @(posedge wr_clk);
      #1;
      base = n_wr;
      fifo_empty = 1'b1;
      seen_busy = 0;
      for (int j = 0; j < 4; j++) begin
         @(posedge wr_clk); #2;
         if (wr_busy) seen_busy = 1;
      end
      fifo_empty = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(posedge wr_clk); #2;
         if (wr_busy) seen_busy = 1;
      end
      check("glitch entered settle", {31'd0, seen_busy}, 32'd1);
      repeat (20) @(posedge wr_clk);
      #2;
      check("glitch busy", {31'd0, wr_busy}, 32'd0);
      check("glitch writes", n_wr - base, 0);

      // Timeout: full held from write 10
      start_burst(10);
      wait_writes(10, 100, ok);
      check("timeout reach 10", {31'd0, ok}, 32'd1);
      #1 fifo_full = 1'b1;
      repeat (TIMEOUT - 1) @(posedge wr_clk);
      #2;
      check("timeout busy before", {31'd0, wr_busy},     32'd1);
      check("timeout terr before", {31'd0, timeout_err}, 32'd0);
      @(posedge wr_clk);
      #2;
      exp_terr = 1;
      end_checks("timeout", 10);
      fifo_full = 1'b0;
      repeat (10) @(posedge wr_clk);
      #2;
      check("timeout no restart", n_wr - base, 10);
      check("terr sticky", {31'd0, timeout_err}, 32'd1);

      // Mid-burst reset after write 50, then a clean burst from 0
      start_burst(BURST_LEN);
      wait_writes(50, 100, ok);
      check("mid reach 50", {31'd0, ok}, 32'd1);
      #3 rst_n = 1'b0;
      #1 check_reset_outputs("mid reset");
      exp_q.delete();
      exp_bursts = 0;
      exp_terr   = 0;
      base = n_wr;
      push_burst(BURST_LEN);
      @(posedge wr_clk); #3;
      check("reset no writes", n_wr - base, 0);
      rst_n = 1'b1;
      wait_done("post reset", 600);
      exp_bursts++;
      end_checks("post reset", BURST_LEN);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
